// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline control and the hazard unit: ID-stage decode,
// the EX branch decision, and the forwarding/stall/flush results plus counters.
interface hazard_ctrl_if;
    logic        freeze;
    logic        id_valid;
    logic [3:0]  id_rs0;
    logic [3:0]  id_rs1;
    logic        id_rs0_used;
    logic        id_rs1_used;
    logic        id_wr_en;
    logic        id_mem_read;
    logic [3:0]  id_wr_reg;
    logic        ex_branch;
    logic [1:0]  fwd_reg0;
    logic [1:0]  fwd_reg1;
    logic        stall;
    logic [4:0]  flush;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    // There is no valid/ready backpressure here: id_valid qualifies the ID
    // fields in the same cycle, and freeze is the only hold on the records.
    modport master (
        output freeze, id_valid, id_rs0, id_rs1, id_rs0_used, id_rs1_used,
               id_wr_en, id_mem_read, id_wr_reg, ex_branch,
        input  fwd_reg0, fwd_reg1, stall, flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  freeze, id_valid, id_rs0, id_rs1, id_rs0_used, id_rs1_used,
               id_wr_en, id_mem_read, id_wr_reg, ex_branch,
        output fwd_reg0, fwd_reg1, stall, flush, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: tracks EX/MEM/WB destination records and
// produces operand forwarding selects, load-use stall, branch flush and counters.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic       valid;
        logic       wr_en;
        logic [3:0] wr_reg;
        logic       mem_read;
    } rec_t;

    rec_t        ex_q, mem_q, wb_q;
    logic [3:0]  ex_rs0_q, ex_rs1_q;
    logic        ex_used0_q, ex_used1_q;
    logic [15:0] stall_cnt_q, flush_cnt_q;
    logic        load_use, lu_stall, branch_go;

    function automatic logic writes(rec_t s, logic [3:0] r);
        return s.valid && s.wr_en && (s.wr_reg == r) && (r != 4'd0);
    endfunction

    // MEM is the younger producer, so it wins over WB; unused sources never forward.
    function automatic logic [1:0] fwd_sel(logic used, logic [3:0] r, rec_t m, rec_t w);
        if (used && writes(m, r)) return 2'b01;
        if (used && writes(w, r)) return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        load_use = bus.id_valid && ex_q.valid && ex_q.mem_read && ex_q.wr_en &&
                   (ex_q.wr_reg != 4'd0) &&
                   ((bus.id_rs0_used && (bus.id_rs0 == ex_q.wr_reg)) ||
                    (bus.id_rs1_used && (bus.id_rs1 == ex_q.wr_reg)));
        lu_stall  = load_use && !bus.ex_branch;
        branch_go = !rst && !bus.freeze && bus.ex_branch;
    end

    assign bus.fwd_reg0  = fwd_sel(ex_used0_q, ex_rs0_q, mem_q, wb_q);
    assign bus.fwd_reg1  = fwd_sel(ex_used1_q, ex_rs1_q, mem_q, wb_q);
    assign bus.stall     = !rst && (bus.freeze || lu_stall);
    assign bus.flush     = {3'b000, branch_go, branch_go};
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            ex_rs0_q    <= 4'd0;
            ex_rs1_q    <= 4'd0;
            ex_used0_q  <= 1'b0;
            ex_used1_q  <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else if (!bus.freeze) begin
            wb_q          <= mem_q;
            mem_q         <= ex_q;
            // A stalled or flushed ID instruction enters EX as a bubble.
            ex_q.valid    <= bus.id_valid && !load_use && !bus.ex_branch;
            ex_q.wr_en    <= bus.id_wr_en;
            ex_q.wr_reg   <= bus.id_wr_reg;
            ex_q.mem_read <= bus.id_mem_read;
            ex_rs0_q      <= bus.id_rs0;
            ex_rs1_q      <= bus.id_rs1;
            ex_used0_q    <= bus.id_rs0_used;
            ex_used1_q    <= bus.id_rs1_used;
            if (lu_stall && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (bus.ex_branch && (flush_cnt_q != 16'hFFFF))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios and random traffic,
// checked against an instruction-history model of the pipeline.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_ctrl_if hif ();

  hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       valid;
    bit       wr_en;
    bit       mem_read;
    bit       u0;
    bit       u1;
    bit [3:0] wr_reg;
    bit [3:0] rs0;
    bit [3:0] rs1;
  } instr_t;

  // History of issued instructions: [0] is in EX, [1] in MEM, [2] in WB.
  instr_t pipe[$];
  int unsigned m_scnt;
  int unsigned m_fcnt;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes(instr_t s, bit [3:0] r);
    return s.valid && s.wr_en && (s.wr_reg == r) && (r != 0);
  endfunction

  function automatic bit [1:0] exp_fwd(bit used, bit [3:0] r);
    if (!used) return 2'b00;
    if (writes(pipe[1], r)) return 2'b01;
    if (writes(pipe[2], r)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit exp_lu();
    instr_t e;
    e = pipe[0];
    if (!(hif.id_valid && e.valid && e.mem_read && e.wr_en && e.wr_reg != 0)) return 1'b0;
    return (hif.id_rs0_used && hif.id_rs0 == e.wr_reg) ||
           (hif.id_rs1_used && hif.id_rs1 == e.wr_reg);
  endfunction

  task automatic model_clear();
    instr_t blank;
    blank = '{default: 0};
    pipe.delete();
    repeat (3) pipe.push_back(blank);
    m_scnt = 0;
    m_fcnt = 0;
  endtask

  task automatic check_all(input string tag);
    bit [1:0] f0, f1;
    bit       st;
    bit [4:0] fl;
    f0 = exp_fwd(pipe[0].u0, pipe[0].rs0);
    f1 = exp_fwd(pipe[0].u1, pipe[0].rs1);
    if (rst) begin
      st = 0; fl = 0;
    end else if (hif.freeze) begin
      st = 1; fl = 0;
    end else if (hif.ex_branch) begin
      st = 0; fl = 5'b00011;
    end else begin
      st = exp_lu(); fl = 0;
    end
    chk({tag, ".fwd0"}, {14'd0, hif.fwd_reg0}, {14'd0, f0});
    chk({tag, ".fwd1"}, {14'd0, hif.fwd_reg1}, {14'd0, f1});
    chk({tag, ".stall"}, {15'd0, hif.stall}, {15'd0, st});
    chk({tag, ".flush"}, {11'd0, hif.flush}, {11'd0, fl});
    chk({tag, ".scnt"}, hif.stall_cnt, m_scnt[15:0]);
    chk({tag, ".fcnt"}, hif.flush_cnt, m_fcnt[15:0]);
  endtask

  // Called at posedge+1 with inputs already applied; returns at next posedge+1.
  task automatic step(input string tag);
    instr_t n;
    bit lu, br;
    #2;
    check_all(tag);
    lu = exp_lu();
    br = hif.ex_branch;
    n.valid    = hif.id_valid && !lu && !br;
    n.wr_en    = hif.id_wr_en;
    n.mem_read = hif.id_mem_read;
    n.u0       = hif.id_rs0_used;
    n.u1       = hif.id_rs1_used;
    n.wr_reg   = hif.id_wr_reg;
    n.rs0      = hif.id_rs0;
    n.rs1      = hif.id_rs1;
    @(posedge clk);
    if (!rst && !hif.freeze) begin
      pipe.push_front(n);
      void'(pipe.pop_back());
      if (lu && !br && m_scnt < 65535) m_scnt++;
      if (br && m_fcnt < 65535) m_fcnt++;
    end
    #1;
  endtask

  task automatic set_id(input bit v, input bit [3:0] rs0, input bit u0,
                        input bit [3:0] rs1, input bit u1, input bit we,
                        input bit [3:0] wr, input bit mr, input bit frz, input bit br);
    hif.id_valid    = v;
    hif.id_rs0      = rs0;
    hif.id_rs0_used = u0;
    hif.id_rs1      = rs1;
    hif.id_rs1_used = u1;
    hif.id_wr_en    = we;
    hif.id_wr_reg   = wr;
    hif.id_mem_read = mr;
    hif.freeze      = frz;
    hif.ex_branch   = br;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();

    // Forward from MEM, then from WB with an independent instruction between.
    set_id(1, 1, 1, 2, 1, 1, 3, 0, 0, 0); step("a1");
    set_id(1, 3, 1, 3, 1, 1, 4, 0, 0, 0); step("a2");
    chk("a_fwd0_mem", {14'd0, hif.fwd_reg0}, 16'h1);
    chk("a_fwd1_mem", {14'd0, hif.fwd_reg1}, 16'h1);
    set_id(1, 1, 1, 2, 1, 1, 8, 0, 0, 0); step("a3");
    set_id(1, 4, 1, 4, 1, 1, 9, 0, 0, 0); step("a4");
    chk("a_fwd0_wb", {14'd0, hif.fwd_reg0}, 16'h2);

    // Load-use: one bubble, then WB forwarding.
    do_reset();
    set_id(1, 1, 1, 0, 0, 1, 5, 1, 0, 0); step("b1");
    set_id(1, 5, 1, 1, 1, 1, 6, 0, 0, 0);
    #1 chk("b_stall_on", {15'd0, hif.stall}, 16'h1);
    step("b2");
    #1 chk("b_stall_off", {15'd0, hif.stall}, 16'h0);
    step("b3");
    chk("b_fwd0_wb", {14'd0, hif.fwd_reg0}, 16'h2);
    chk("b_scnt", hif.stall_cnt, 16'h1);

    // MEM beats WB; register 0 is never a hazard.
    do_reset();
    set_id(1, 1, 1, 1, 1, 1, 2, 0, 0, 0); step("c1");
    set_id(1, 1, 1, 1, 1, 1, 2, 0, 0, 0); step("c2");
    set_id(1, 2, 1, 2, 1, 1, 7, 0, 0, 0); step("c3");
    chk("c_fwd0_mem_wins", {14'd0, hif.fwd_reg0}, 16'h1);
    set_id(1, 1, 1, 1, 1, 1, 0, 1, 0, 0); step("c4");
    set_id(1, 0, 1, 0, 1, 1, 6, 0, 0, 0);
    #1 chk("c_r0_nostall", {15'd0, hif.stall}, 16'h0);
    step("c5");
    chk("c_r0_fwd0", {14'd0, hif.fwd_reg0}, 16'h0);

    // Branch coincident with a load-use hit.
    do_reset();
    set_id(1, 1, 1, 0, 0, 1, 5, 1, 0, 0); step("d1");
    set_id(1, 5, 1, 0, 0, 1, 9, 1, 0, 1);
    #1 chk("d_flush", {11'd0, hif.flush}, 16'h3);
    chk("d_stall", {15'd0, hif.stall}, 16'h0);
    step("d2");
    set_id(1, 9, 1, 0, 0, 1, 4, 0, 0, 0);
    #1 chk("d_ex_bubble", {15'd0, hif.stall}, 16'h0);
    chk("d_fcnt", hif.flush_cnt, 16'h1);
    chk("d_scnt", hif.stall_cnt, 16'h0);
    step("d3");

    // Freeze during forwarding, then counter saturation.
    do_reset();
    set_id(1, 1, 1, 2, 1, 1, 3, 0, 0, 0); step("e1");
    set_id(1, 3, 1, 3, 1, 1, 4, 0, 0, 0); step("e2");
    for (int i = 0; i < 3; i++) begin
      set_id(1, 4, 1, 1, 1, 1, 5, 0, 1, i == 2);
      #1 chk("e_frz_fwd0", {14'd0, hif.fwd_reg0}, 16'h1);
      chk("e_frz_stall", {15'd0, hif.stall}, 16'h1);
      step("e_frz");
    end
    set_id(1, 4, 1, 1, 1, 1, 5, 0, 0, 1); step("e_branch_after_frz");
    force dut.stall_cnt_q = 16'hFFFE;
    #1 release dut.stall_cnt_q;
    m_scnt = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      set_id(1, 1, 1, 0, 0, 1, 5, 1, 0, 0); step("e_lw");
      set_id(1, 5, 1, 0, 0, 1, 6, 0, 0, 0); step("e_use");
      step("e_use2");
    end
    chk("e_scnt_sat", hif.stall_cnt, 16'hFFFF);

    // Reset in the middle of a load-use stall.
    do_reset();
    set_id(1, 1, 1, 0, 0, 1, 5, 1, 0, 0); step("f1");
    set_id(1, 5, 1, 0, 0, 1, 6, 0, 0, 0); step("f2");
    set_id(1, 5, 1, 0, 0, 1, 6, 0, 0, 0);
    #1 chk("f_pre_stall", {15'd0, hif.stall}, 16'h0);
    set_id(1, 1, 1, 0, 0, 1, 5, 1, 0, 0); step("f3");
    set_id(1, 5, 1, 0, 0, 1, 6, 0, 0, 0);
    #1 chk("f_stall_set", {15'd0, hif.stall}, 16'h1);
    do_reset();
    chk("f_rst_scnt", hif.stall_cnt, 16'h0);
    set_id(1, 1, 1, 2, 1, 1, 3, 0, 0, 0); step("f4");
    set_id(1, 3, 1, 3, 1, 1, 4, 0, 0, 0); step("f5");
    chk("f_resume_fwd", {14'd0, hif.fwd_reg0}, 16'h1);

    // Random traffic over a small register set to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      set_id($urandom_range(0, 9) != 0, 4'($urandom_range(0, 3)), 1'($urandom),
             4'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 4) != 0,
             4'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      else step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  async active-high reset.
REQ-004 Port: freeze  input  1  global pipeline hold (memory not ready).
REQ-005 Port: id_valid  input  1  ID stage holds a real instruction.
REQ-006 Port: id_rs0, id_rs1  input  4 each  ID source register numbers.
REQ-007 Port: id_rs0_used, id_rs1_used  input  1 each  source is actually read.
REQ-008 Port: id_wr_en, id_mem_read  input  1 each  ID instr writes a register / is a load.
REQ-009 Port: id_wr_reg  input  4  ID destination register.
REQ-010 Port: ex_branch  input  1  taken-branch decision from EX stage.
REQ-011 Port: fwd_reg0, fwd_reg1  output  2 each  EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB write data, 11 never driven.
REQ-012 Port: stall  output  1  hold PC and IF/ID.
REQ-013 Port: flush  output  5  [0] squash IF/ID, [1] squash ID/EX, [4:2] tied 0.
REQ-014 Port: stall_cnt, flush_cnt  output  16 each  saturating event counters.

Function
REQ-015 SHALL keep three stage records, EX, MEM, WB; each holds {valid, wr_en, wr_reg, mem_read}, and EX additionally holds {rs0, rs1, rs0_used, rs1_used}.
REQ-016 Each non-frozen edge SHALL shift the records: WB<=MEM, MEM<=EX, EX<=ID inputs. EX.valid<=0 if stall, flush[1] or !id_valid.
REQ-017 A record "writes r" iff valid & wr_en & wr_reg==r & r!=0; register 0 SHALL never forward or cause a stall.
REQ-018 fwd_regN SHALL be combinational from the records only: 01 if EX.rsN_used & MEM writes EX.rsN; else 10 if WB writes EX.rsN; else 00. MEM SHALL win over WB.
REQ-019 Load-use: stall=1 when id_valid & EX.valid & EX.mem_read & EX.wr_en, EX.wr_reg!=0, and a used ID source equals EX.wr_reg. This SHALL insert exactly one bubble; the next cycle the load is in MEM and stall deasserts.
REQ-020 Branch: when ex_branch=1, flush SHALL be 5'b00011 in the same cycle and stall=0. Branch SHALL take priority over load-use.
REQ-021 While freeze=1: records and counters SHALL hold, stall=1, flush=0, and fwd outputs SHALL still reflect the held records. A pending ex_branch takes effect on the first non-frozen cycle.
REQ-022 stall_cnt SHALL increment on each non-frozen edge with load-use stall=1. flush_cnt SHALL increment on each non-frozen edge with ex_branch=1. Both SHALL saturate at 16'hFFFF with no wrap.
REQ-023 Outputs stall and flush SHALL be combinational. Record and counter updates SHALL take effect one cycle after the causing condition.

Reset
REQ-024 rst=1 SHALL immediately clear all record valid bits and both counters. Outputs SHALL then be fwd 00/00, stall 0, flush 0, counters 0, independent of clk.
REQ-025 Reset mid-stall or mid-flush SHALL abandon the event. The first post-reset edge SHALL load the EX record from ID inputs normally.

Verification
REQ-026 ADD r3 in ID, then ADD r4,r3,r3 next cycle -> second instr in EX with fwd_reg0=fwd_reg1=01; one cycle later with an independent instr between -> 10.
REQ-027 LW r5 followed by ADD r6,r5,r1 -> stall=1 for exactly one cycle, then fwd_reg0=10 for the ADD; stall_cnt 0->1.
REQ-028 Both MEM and WB write r2 and the EX instr reads r2 -> fwd=01. Any instr targeting r0 -> fwd stays 00 and stall stays 0.
REQ-029 ex_branch=1 in the same cycle as a load-use hit -> flush=00011, stall=0, flush_cnt +1, stall_cnt unchanged, EX record invalid next cycle.
REQ-030 freeze=1 for 3 cycles during a forwarding case -> fwd constant, stall=1, counters unchanged. Preset stall_cnt=FFFF plus another load-use -> stays FFFF.
REQ-031 Assert rst during a load-use stall -> stall=0, counters 0 with no clock edge; normal forwarding resumes after release.
